serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Handshaked operands in, handshaked {sum, cout, ovf} out after WIDTH cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             carry_reg, cout_reg, ovf_reg;
  logic             last_bit, a_bit, b_bit, s_bit, c_next;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // Operand copies shift right each RUN cycle, so bit i is always at position 0.
  assign a_bit  = a_reg[0];
  assign b_bit  = b_reg[0];
  assign s_bit  = a_bit ^ b_bit ^ carry_reg;
  assign c_next = (a_bit & b_bit) | (carry_reg & (a_bit ^ b_bit));

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_result
      assign result_next[gi] = (cnt_reg == CW'(gi)) ? s_bit : result_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          result_reg <= result_next;
          carry_reg  <= c_next;
          cnt_reg    <= cnt_reg + 1'b1;
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          // carry_reg is the carry into the MSB while the last bit is processed
          if (last_bit) begin
            cout_reg <= c_next;
            ovf_reg  <= carry_reg ^ c_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = result_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
